// File: rtl/dmem_master.sv
// ============================================================================
// Module      : dmem_master
// Description : RV32 load/store requester for a single-port 32-bit data
//               memory. Generates the word address, byte enables and lane
//               data, and returns extended load data one cycle after accept.
//               Optional macro DMEM_MISALIGN_SPLIT_EN turns misaligned H/W
//               accesses into two back-to-back word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_master #(
    parameter int unsigned DMEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dmem_en,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_d,
    output logic [3:0]  dmem_we,
    input  logic [31:0] dmem_q
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RESP   = 2'd1;
    // The first word of a split access is issued in the accept cycle
    // (phase 1); S_SPLIT2 issues the second word.
    localparam logic [1:0] S_SPLIT2 = 2'd2;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    logic [1:0]  r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_store;
    logic        r_err;

    logic [1:0]  w_off;
    logic [31:0] w_widx;
    logic        w_f3_ok;
    logic        w_st_ok;
    logic        w_range_ok;
    logic        w_misalign;
    logic        w_err;
    logic        w_split;
    logic        w_accept;
    logic [3:0]  w_mask;
    logic [31:0] w_repl;
    logic [31:0] w_lo_word;
    logic [31:0] w_shw;

    assign w_off      = req_addr[1:0];
    assign w_widx     = {2'b00, req_addr[31:2]};
    assign w_f3_ok    = (req_funct3 == c_F3_B)  || (req_funct3 == c_F3_H) ||
                        (req_funct3 == c_F3_W)  || (req_funct3 == c_F3_BU) ||
                        (req_funct3 == c_F3_HU);
    // Unsigned variants have no meaning for stores.
    assign w_st_ok    = !(req_we && req_funct3[2]);
    assign w_range_ok = (w_widx < DMEM_WORDS);
    // Halfword crossing a word boundary, or an unaligned word.
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && (w_off == 2'b11)) ||
                        ((req_funct3[1:0] == 2'b10) && (w_off != 2'b00));

    // Size mask before lane shift and right-aligned data replicated per width.
    always_comb begin
        w_mask = 4'b0001;
        w_repl = {4{req_wdata[7:0]}};
        if (req_funct3[1:0] == 2'b01) begin
            w_mask = 4'b0011;
            w_repl = {2{req_wdata[15:0]}};
        end else if (req_funct3[1:0] == 2'b10) begin
            w_mask = 4'b1111;
            w_repl = req_wdata;
        end
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic        r_split;
    logic [31:0] r_lo;
    logic [31:0] r_addr_hi;
    logic [31:0] r_d_hi;
    logic [3:0]  r_we_hi;
    logic [31:0] w_widx_hi;
    logic [7:0]  w_mask8;
    logic [63:0] w_lane64;

    assign w_widx_hi = w_widx + 32'd1;
    assign w_err     = !w_f3_ok || !w_st_ok || !w_range_ok ||
                       (w_misalign && (w_widx_hi >= DMEM_WORDS));
    assign w_split   = w_misalign && !w_err;
    assign w_mask8   = {4'b0000, w_mask} << w_off;

    // Store data placed across two adjacent words by byte offset.
    always_comb begin
        w_lane64 = {32'd0, req_wdata};
        case (w_off)
            2'b01:   w_lane64 = {24'd0, req_wdata, 8'd0};
            2'b10:   w_lane64 = {16'd0, req_wdata, 16'd0};
            2'b11:   w_lane64 = {8'd0, req_wdata, 24'd0};
            default: w_lane64 = {32'd0, req_wdata};
        endcase
    end

    assign w_lo_word = r_split ? r_lo : dmem_q;
`else
    assign w_err     = !w_f3_ok || !w_st_ok || !w_range_ok || w_misalign;
    assign w_split   = 1'b0;
    assign w_lo_word = dmem_q;
`endif

    assign req_ready = !rst && ((r_state == S_IDLE) ||
                                ((r_state == S_RESP) && resp_ready));
    assign w_accept  = req_valid && req_ready;

    // Memory port strobes: issued combinationally in the accept cycle.
    always_comb begin
        dmem_en   = 1'b0;
        dmem_addr = w_widx;
        dmem_d    = w_repl;
        dmem_we   = 4'b0000;
        if (w_accept && !w_err) begin
            dmem_en = 1'b1;
`ifdef DMEM_MISALIGN_SPLIT_EN
            if (w_split) begin
                dmem_d = w_lane64[31:0];
            end
            if (req_we) begin
                dmem_we = w_mask8[3:0];
            end
`else
            if (req_we) begin
                dmem_we = w_mask << w_off;
            end
`endif
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        if ((r_state == S_SPLIT2) && !rst) begin
            dmem_en   = 1'b1;
            dmem_addr = r_addr_hi;
            dmem_d    = r_d_hi;
            dmem_we   = r_we_hi;
        end
`endif
    end

    // State and captured request attributes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_funct3 <= 3'b000;
            r_off    <= 2'b00;
            r_store  <= 1'b0;
            r_err    <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            r_split   <= 1'b0;
            r_lo      <= 32'd0;
            r_addr_hi <= 32'd0;
            r_d_hi    <= 32'd0;
            r_we_hi   <= 4'b0000;
`endif
        end else begin
            if (w_accept) begin
                r_funct3 <= req_funct3;
                r_off    <= w_off;
                r_store  <= req_we;
                r_err    <= w_err;
                r_state  <= w_split ? S_SPLIT2 : S_RESP;
`ifdef DMEM_MISALIGN_SPLIT_EN
                r_split   <= w_split;
                r_addr_hi <= w_widx_hi;
                r_d_hi    <= w_lane64[63:32];
                r_we_hi   <= req_we ? w_mask8[7:4] : 4'b0000;
`endif
            end else if ((r_state == S_RESP) && resp_ready) begin
                r_state <= S_IDLE;
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            else if (r_state == S_SPLIT2) begin
                r_lo    <= dmem_q;
                r_state <= S_RESP;
            end
`endif
        end
    end

    // Realign the returned word(s) so the addressed byte sits in lane 0.
    always_comb begin
        w_shw = w_lo_word;
        case (r_off)
            2'b01:   w_shw = {dmem_q[7:0],  w_lo_word[31:8]};
            2'b10:   w_shw = {dmem_q[15:0], w_lo_word[31:16]};
            2'b11:   w_shw = {dmem_q[23:0], w_lo_word[31:24]};
            default: w_shw = w_lo_word;
        endcase
    end

    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = (r_state == S_RESP) && r_err;

    // Load data extension; stores, faults and idle cycles return zero.
    always_comb begin
        resp_rdata = 32'd0;
        if ((r_state == S_RESP) && !r_err && !r_store) begin
            case (r_funct3)
                c_F3_B:  resp_rdata = {{24{w_shw[7]}}, w_shw[7:0]};
                c_F3_H:  resp_rdata = {{16{w_shw[15]}}, w_shw[15:0]};
                c_F3_BU: resp_rdata = {24'd0, w_shw[7:0]};
                c_F3_HU: resp_rdata = {16'd0, w_shw[15:0]};
                default: resp_rdata = w_shw;
            endcase
        end
    end

endmodule

`default_nettype wire
